// File: rtl/csa_resolve_serial.sv
// Sequential carry-save to binary resolver: returns S + 2*C, resolving CHUNK bits
// per cycle through a registered carry so the adder path stays CHUNK bits long.
module csa_resolve_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_result
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int RW    = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cy_q, cy_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [RW-1:0]    res_q, res_d;

    logic [31:0]      shamt;
    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK:0]   csum;
    logic             last_chk;

    // One CHUNK-bit slice of the ripple per cycle, selected by the chunk index.
    always_comb begin
        shamt    = 32'(idx_q) * 32'(CHUNK);
        a_chk    = CHUNK'(a_q >> shamt);
        b_chk    = CHUNK'(b_q >> shamt);
        csum     = {1'b0, a_chk} + {1'b0, b_chk} + (CHUNK+1)'(cy_q);
        last_chk = (idx_q == IDX_W'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    a_d     = in_sum;
                    b_d     = {in_carry, 1'b0};
                    cy_d    = 1'b0;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // res_q was cleared on accept, so each slice can simply be OR-ed in.
                res_d = res_q | (RW'(csum[CHUNK-1:0]) << shamt);
                cy_d  = csum[CHUNK];
                idx_d = idx_q + IDX_W'(1);
                if (last_chk) begin
                    res_d[WIDTH+1:WIDTH] = {1'b0, csum[CHUNK]} + {1'b0, b_q[WIDTH]};
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            rdy_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            rdy_q   <= rdy_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Bench for csa_resolve_serial: four instances (8/4, 32/8, 32/1, 8/8) checked
// against an arithmetic S + 2*C model plus hand-computed literal results.
module tb_csa_resolve_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  iv;
    logic [3:0]  ordy_dir;
    logic [3:0]  ordy_rnd;
    logic        rand_rdy;
    logic [3:0]  ordy;
    logic [31:0] s_in [4];
    logic [31:0] c_in [4];

    logic        ir0, ir1, ir2, ir3;
    logic        ov0, ov1, ov2, ov3;
    logic [9:0]  r0, r3;
    logic [33:0] r1, r2;
    logic [3:0]  ir, ov;
    logic [33:0] res [4];

    assign ordy   = rand_rdy ? ordy_rnd : ordy_dir;
    assign ir     = {ir3, ir2, ir1, ir0};
    assign ov     = {ov3, ov2, ov1, ov0};
    assign res[0] = {24'b0, r0};
    assign res[1] = r1;
    assign res[2] = r2;
    assign res[3] = {24'b0, r3};

    csa_resolve_serial #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .in_sum(s_in[0][7:0]), .in_carry(c_in[0][7:0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_result(r0));

    csa_resolve_serial #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .in_sum(s_in[1]), .in_carry(c_in[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_result(r1));

    csa_resolve_serial #(.WIDTH(32), .CHUNK(1)) u_w32c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
        .in_sum(s_in[2]), .in_carry(c_in[2]),
        .out_valid(ov2), .out_ready(ordy[2]), .out_result(r2));

    csa_resolve_serial #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir3),
        .in_sum(s_in[3][7:0]), .in_carry(c_in[3][7:0]),
        .out_valid(ov3), .out_ready(ordy[3]), .out_result(r3));

    int vectors     = 0;
    int miscompares = 0;
    logic [33:0] expq [4][$];

    function automatic int nchunks(input int d);
        case (d)
            0:       return 2;
            1:       return 4;
            2:       return 32;
            default: return 1;
        endcase
    endfunction

    function automatic logic [33:0] model(input int d, input logic [31:0] s, input logic [31:0] c);
        logic [31:0] m;
        m = (d == 0 || d == 3) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        return 34'(s & m) + (34'(c & m) << 1);
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input logic [31:0] s, input logic [31:0] c);
        int n;
        n = 0;
        s_in[d] = s;
        c_in[d] = c;
        iv[d]   = 1'b1;
        while (!ir[d] && n < 200) begin
            tick();
            n++;
        end
        if (!ir[d]) chk($sformatf("in_ready_timeout[%0d]", d), 34'(ir[d]), 34'd1);
        tick();
        expq[d].push_back(model(d, s, c));
        iv[d]   = 1'b0;
        s_in[d] = $urandom;
        c_in[d] = $urandom;
    endtask

    task automatic wait_valid(input int d, output int cnt);
        cnt = 0;
        while (!ov[d] && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic finish_one(input int d, input string name, input logic [33:0] lit);
        int cnt;
        wait_valid(d, cnt);
        chk({name, "_latency"}, 34'(cnt), 34'(nchunks(d)));
        chk(name, res[d], lit);
        ordy_dir[d] = 1'b1;
        tick();
        ordy_dir[d] = 1'b0;
    endtask

    task automatic rand_run(input int d, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            issue(d, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    always @(posedge clk) ordy_rnd <= 4'($urandom);

    // Reference check on every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 4; d++) begin
                if (ov[d]) begin
                    if (expq[d].size() == 0) begin
                        chk($sformatf("spurious_valid[%0d]", d), 34'(ov[d]), 34'd0);
                    end else begin
                        chk($sformatf("result[%0d]", d), res[d], expq[d][0]);
                        if (ordy[d]) void'(expq[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int n;
        rst_n    = 1'b0;
        iv       = '0;
        ordy_dir = '0;
        rand_rdy = 1'b0;
        for (int d = 0; d < 4; d++) begin
            s_in[d] = '0;
            c_in[d] = '0;
        end
        repeat (3) tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_in_ready[%0d]", d), 34'(ir[d]), 34'd0);
            chk($sformatf("rst_out_valid[%0d]", d), 34'(ov[d]), 34'd0);
            chk($sformatf("rst_result[%0d]", d), res[d], 34'd0);
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 4; d++)
            chk($sformatf("ready_after_release[%0d]", d), 34'(ir[d]), 34'd1);

        // 8/4: all-ones pair, then the handshake back to IDLE.
        issue(0, 32'hFF, 32'hFF);
        finish_one(0, "w8c4_ff_ff", 34'h2FD);
        chk("w8c4_valid_drop", 34'(ov[0]), 34'd0);
        chk("w8c4_ready_back", 34'(ir[0]), 34'd1);
        chk("w8c4_result_holds", res[0], 34'h2FD);

        issue(0, 32'h00, 32'h80);
        finish_one(0, "w8c4_top_carry", 34'h100);
        issue(0, 32'h01, 32'h7F);
        finish_one(0, "w8c4_chunk_ripple", 34'h0FF);

        issue(1, 32'hFFFF_FFFF, 32'h0000_0001);
        finish_one(1, "w32c8_full_ripple", 34'h1_0000_0001);
        issue(1, 32'h0, 32'h0);
        finish_one(1, "w32c8_zero", 34'h0);

        issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_one(2, "w32c1_max", 34'h2_FFFF_FFFD);
        issue(3, 32'hFF, 32'hFF);
        finish_one(3, "w8c8_max", 34'h2FD);

        // Backpressure: hold the result, ignore in_valid pulses, then one transfer.
        issue(1, 32'h1234_5678, 32'h0F0F_0F0F);
        wait_valid(1, cnt);
        chk("bp_latency", 34'(cnt), 34'd4);
        for (int i = 0; i < 5; i++) begin
            iv[1]   = (i % 2 == 0);
            s_in[1] = $urandom;
            c_in[1] = $urandom;
            tick();
            chk("bp_valid", 34'(ov[1]), 34'd1);
            chk("bp_hold", res[1], 34'h3052_7496);
            chk("bp_ready", 34'(ir[1]), 34'd0);
        end
        iv[1]       = 1'b0;
        ordy_dir[1] = 1'b1;
        tick();
        ordy_dir[1] = 1'b0;
        chk("bp_release_valid", 34'(ov[1]), 34'd0);
        repeat (6) begin
            tick();
            chk("bp_single_transfer", 34'(ov[1]), 34'd0);
        end
        chk("bp_queue_empty", 34'(expq[1].size()), 34'd0);

        // Reset while the 32/8 instance is at chunk index 1.
        issue(1, 32'hAAAA_5555, 32'h0000_1234);
        tick();
        rst_n = 1'b0;
        tick();
        for (int d = 0; d < 4; d++) expq[d].delete();
        chk("abort_ready_low", 34'(ir[1]), 34'd0);
        chk("abort_valid_low", 34'(ov[1]), 34'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_ready_high", 34'(ir[1]), 34'd1);
        repeat (6) begin
            tick();
            chk("abort_no_result", 34'(ov[1]), 34'd0);
        end
        issue(1, 32'h12, 32'h34);
        finish_one(1, "after_abort", 34'h7A);

        // Random regression across all chunk sizes with random out_ready.
        rand_rdy = 1'b1;
        fork
            rand_run(0, 400);
            rand_run(1, 300);
            rand_run(2, 120);
            rand_run(3, 300);
        join
        n = 0;
        while ((expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0 && n < 2000) begin
            tick();
            n++;
        end
        for (int d = 0; d < 4; d++)
            chk($sformatf("drain[%0d]", d), 34'(expq[d].size()), 34'd0);
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
